atm_session_ctrl: RTL and testbench

Session sequencer for the crypto ATM. It owns the one-hot `current_state` and the `input_style` code that the keypad/ASCII user-input block consumes, and advances on that block's `ready` edges. It also issues verification requests (account, PIN, amount) to the account/ledger unit and enforces PIN-retry, exit and inactivity-timeout policy.

---
 rtl/atm_session_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// Session sequencer for the crypto ATM: walks the user through login, menu and transaction
// screens, issues ledger verification requests and enforces PIN-retry, exit and timeout policy.
module atm_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 300000000,
  parameter int unsigned MSG_CYCLES     = 200000000,
  parameter int unsigned PIN_TRIES      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ready,
  input  logic [1:0]  usr_input,
  input  logic        exit_req,
  input  logic        check_done,
  input  logic        check_pass,
  output logic [15:0] current_state,
  output logic [3:0]  input_style,
  output logic        check_req,
  output logic [1:0]  check_kind,
  output logic        clear_input,
  output logic        session_active
);

  localparam int TRY_W = (PIN_TRIES < 1) ? 1 : $clog2(PIN_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT    = TRY_W'(PIN_TRIES);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      MSG_LAST     = 32'(MSG_CYCLES - 1);

  localparam logic [3:0] STY_NONE     = 4'b0000;
  localparam logic [3:0] STY_SINGLE   = 4'b0001;
  localparam logic [3:0] STY_ACC      = 4'b0010;
  localparam logic [3:0] STY_PIN      = 4'b0011;
  localparam logic [3:0] STY_MENU     = 4'b0100;
  localparam logic [3:0] STY_CURRENCY = 4'b0101;
  localparam logic [3:0] STY_AMOUNT   = 4'b0110;

  localparam logic [1:0] KIND_ACC    = 2'b00;
  localparam logic [1:0] KIND_PIN    = 2'b01;
  localparam logic [1:0] KIND_AMOUNT = 2'b10;
  localparam logic [1:0] KIND_XFER   = 2'b11;

  // Values equal the one-hot bit index driven on current_state.
  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_ACC_NUM       = 4'd1,
    S_PIN_INPUT     = 4'd2,
    S_MENU          = 4'd3,
    S_SHOW_BALANCES = 4'd4,
    S_CONVERT       = 4'd5,
    S_SEL_CONV_1    = 4'd6,
    S_SEL_CONV_2    = 4'd7,
    S_WITHDRAW      = 4'd8,
    S_SEL_AMT_WD    = 4'd9,
    S_TRANSFER      = 4'd10,
    S_SEL_CUR_XFER  = 4'd11,
    S_SEL_AMT_XFER  = 4'd12,
    S_ERROR         = 4'd13,
    S_SUCCESS       = 4'd14
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q;
  logic [31:0]      timer_q, timer_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic             req_q, req_d;
  logic [1:0]       kind_q, kind_d;
  logic             pin_retry;
  logic             ready_rise;
  logic             dwell;

  logic [15:0]      cur_state_q, cur_state_d;
  logic [3:0]       style_q, style_d;
  logic             clear_q, clear_d;
  logic             active_q, active_d;

  assign ready_rise = ready & ~ready_q;
  assign dwell      = (state_q == S_ERROR) || (state_q == S_SUCCESS);
  assign tries_inc  = tries_q + TRY_W'(1);

  // State register; the externally visible outputs are registered alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      timer_q     <= '0;
      tries_q     <= '0;
      req_q       <= 1'b0;
      kind_q      <= KIND_ACC;
      cur_state_q <= 16'h0001;
      style_q     <= STY_SINGLE;
      clear_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready;
      timer_q     <= timer_d;
      tries_q     <= tries_d;
      req_q       <= req_d;
      kind_q      <= kind_d;
      cur_state_q <= cur_state_d;
      style_q     <= style_d;
      clear_q     <= clear_d;
      active_q    <= active_d;
    end
  end

  // Next-state logic. Priority: exit > check result > dwell/timeout > ready edge.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    kind_d    = kind_q;
    tries_d   = tries_q;
    pin_retry = 1'b0;

    if (exit_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
    end else if (check_done && req_q) begin
      req_d = 1'b0;
      case (state_q)
        S_ACC_NUM: state_d = check_pass ? S_PIN_INPUT : S_ERROR;
        S_PIN_INPUT: begin
          if (check_pass) begin
            state_d = S_MENU;
            tries_d = '0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRY_LIMIT) begin
              state_d = S_ERROR;
            end else begin
              pin_retry = 1'b1;
            end
          end
        end
        S_SEL_CONV_2, S_SEL_AMT_WD, S_SEL_AMT_XFER:
          state_d = check_pass ? S_SUCCESS : S_ERROR;
        default: state_d = S_ERROR;
      endcase
    end else if (dwell) begin
      if (timer_q == MSG_LAST) begin
        state_d = (state_q == S_SUCCESS) ? S_MENU : S_IDLE;
      end
    end else if ((state_q != S_IDLE) && (timer_q == TIMEOUT_LAST)) begin
      state_d = S_ERROR;
      req_d   = 1'b0;
    end else if (ready_rise && !req_q) begin
      case (state_q)
        S_IDLE:          state_d = S_ACC_NUM;
        S_ACC_NUM: begin
          req_d  = 1'b1;
          kind_d = KIND_ACC;
        end
        S_PIN_INPUT: begin
          req_d  = 1'b1;
          kind_d = KIND_PIN;
        end
        S_MENU: begin
          case (usr_input)
            2'b00:   state_d = S_SHOW_BALANCES;
            2'b01:   state_d = S_CONVERT;
            2'b10:   state_d = S_WITHDRAW;
            default: state_d = S_TRANSFER;
          endcase
        end
        S_SHOW_BALANCES: state_d = S_MENU;
        S_CONVERT:       state_d = S_SEL_CONV_1;
        S_SEL_CONV_1:    state_d = S_SEL_CONV_2;
        S_SEL_CONV_2: begin
          req_d  = 1'b1;
          kind_d = KIND_XFER;
        end
        S_WITHDRAW:      state_d = S_SEL_AMT_WD;
        S_SEL_AMT_WD: begin
          req_d  = 1'b1;
          kind_d = KIND_AMOUNT;
        end
        S_TRANSFER:      state_d = S_SEL_CUR_XFER;
        S_SEL_CUR_XFER:  state_d = S_SEL_AMT_XFER;
        S_SEL_AMT_XFER: begin
          req_d  = 1'b1;
          kind_d = KIND_XFER;
        end
        default:         state_d = state_q;
      endcase
    end

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      tries_d = '0;
    end

    // The dwell count in ERROR/SUCCESS must not be disturbed by stray ready edges.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_IDLE) begin
      timer_d = '0;
    end else if (ready_rise && !dwell) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Output decode from the next state, so the registered outputs line up with state_q.
  always_comb begin
    cur_state_d = 16'h0001 << state_d;
    active_d    = (state_d != S_IDLE);
    clear_d     = (state_d != state_q) || pin_retry;
    case (state_d)
      S_IDLE:          style_d = STY_SINGLE;
      S_ACC_NUM:       style_d = STY_ACC;
      S_PIN_INPUT:     style_d = STY_PIN;
      S_MENU:          style_d = STY_MENU;
      S_SHOW_BALANCES: style_d = STY_SINGLE;
      S_CONVERT:       style_d = STY_SINGLE;
      S_SEL_CONV_1:    style_d = STY_CURRENCY;
      S_SEL_CONV_2:    style_d = STY_CURRENCY;
      S_WITHDRAW:      style_d = STY_SINGLE;
      S_SEL_AMT_WD:    style_d = STY_AMOUNT;
      S_TRANSFER:      style_d = STY_ACC;
      S_SEL_CUR_XFER:  style_d = STY_CURRENCY;
      S_SEL_AMT_XFER:  style_d = STY_AMOUNT;
      default:         style_d = STY_NONE;
    endcase
  end

  assign current_state  = cur_state_q;
  assign input_style    = style_q;
  assign check_req      = req_q;
  assign check_kind     = kind_q;
  assign clear_input    = clear_q;
  assign session_active = active_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: a vector table for the main flows plus
// hand-written sequences for lockout, timeout, held-ready, simultaneous events and reset.
module tb_atm_session_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic [1:0]  usr_input = 2'b00;
  logic        exit_req = 1'b0;
  logic        check_done = 1'b0;
  logic        check_pass = 1'b0;
  logic [15:0] current_state;
  logic [3:0]  input_style;
  logic        check_req;
  logic [1:0]  check_kind;
  logic        clear_input;
  logic        session_active;

  int total = 0;
  int passed = 0;

  atm_session_ctrl #(
    .TIMEOUT_CYCLES(20),
    .MSG_CYCLES(5),
    .PIN_TRIES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ready(ready),
    .usr_input(usr_input),
    .exit_req(exit_req),
    .check_done(check_done),
    .check_pass(check_pass),
    .current_state(current_state),
    .input_style(input_style),
    .check_req(check_req),
    .check_kind(check_kind),
    .clear_input(clear_input),
    .session_active(session_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [1:0]  usr;
    logic        ex;
    logic        dn;
    logic        ps;
    logic [15:0] st;
    logic [3:0]  sty;
    logic        req;
    logic [1:0]  knd;
    logic        clr;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic r, input logic [1:0] u, input logic e, input logic d,
                     input logic p, input logic [15:0] st, input logic [3:0] sty,
                     input logic rq, input logic [1:0] k, input logic c);
    vecs[nv].rdy = r;  vecs[nv].usr = u;   vecs[nv].ex = e;  vecs[nv].dn = d;
    vecs[nv].ps = p;   vecs[nv].st = st;   vecs[nv].sty = sty;
    vecs[nv].req = rq; vecs[nv].knd = k;   vecs[nv].clr = c;
    nv++;
  endtask

  task automatic step(input logic r, input logic [1:0] u, input logic e, input logic d,
                      input logic p);
    @(negedge clk);
    ready = r; usr_input = u; exit_req = e; check_done = d; check_pass = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  initial begin
    // Main flows: happy path, transfer with success dwell, exit mid-withdraw check.
    add(1, 0, 0, 0, 0, 16'h0002, 4'd2, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0002, 4'd2, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0002, 4'd2, 1, 2'd0, 0);
    add(0, 0, 0, 0, 0, 16'h0002, 4'd2, 1, 2'd0, 0);
    add(0, 0, 0, 1, 1, 16'h0004, 4'd3, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0004, 4'd3, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0004, 4'd3, 1, 2'd1, 0);
    add(0, 0, 0, 1, 1, 16'h0008, 4'd4, 0, 2'd1, 1);
    add(1, 0, 0, 0, 0, 16'h0010, 4'd1, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0010, 4'd1, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0008, 4'd4, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0008, 4'd4, 0, 2'd0, 0);
    add(1, 3, 0, 0, 0, 16'h0400, 4'd2, 0, 2'd0, 1);
    add(0, 3, 0, 0, 0, 16'h0400, 4'd2, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0800, 4'd5, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0800, 4'd5, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h1000, 4'd6, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h1000, 4'd6, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h1000, 4'd6, 1, 2'd3, 0);
    add(0, 0, 0, 1, 1, 16'h4000, 4'd0, 0, 2'd3, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 16'h4000, 4'd0, 0, 2'd0, 0);
    add(0, 0, 0, 0, 0, 16'h0008, 4'd4, 0, 2'd0, 1);
    add(1, 2, 0, 0, 0, 16'h0100, 4'd1, 0, 2'd0, 1);
    add(0, 2, 0, 0, 0, 16'h0100, 4'd1, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0200, 4'd6, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0200, 4'd6, 0, 2'd0, 0);
    add(1, 0, 0, 0, 0, 16'h0200, 4'd6, 1, 2'd2, 0);
    add(0, 0, 1, 0, 0, 16'h0001, 4'd1, 0, 2'd0, 1);
    add(0, 0, 0, 0, 0, 16'h0001, 4'd1, 0, 2'd0, 0);
    add(0, 0, 0, 1, 1, 16'h0001, 4'd1, 0, 2'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset state", current_state, 32'h0001);
    chk("reset style", input_style, 32'h1);
    chk("reset req", check_req, 32'h0);
    chk("reset kind", check_kind, 32'h0);
    chk("reset clear", clear_input, 32'h0);
    chk("reset active", session_active, 32'h0);

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].rdy, vecs[i].usr, vecs[i].ex, vecs[i].dn, vecs[i].ps);
      chk($sformatf("vec%0d state", i), current_state, 32'(vecs[i].st));
      chk($sformatf("vec%0d style", i), input_style, 32'(vecs[i].sty));
      chk($sformatf("vec%0d req", i), check_req, 32'(vecs[i].req));
      chk($sformatf("vec%0d clear", i), clear_input, 32'(vecs[i].clr));
      chk($sformatf("vec%0d active", i), session_active, 32'(vecs[i].st != 16'h0001));
      if (vecs[i].req) chk($sformatf("vec%0d kind", i), check_kind, 32'(vecs[i].knd));
      $display("vec %0d: state=%04h style=%0h req=%0b kind=%0d clear=%0b",
               i, current_state, input_style, check_req, check_kind, clear_input);
    end

    // PIN lockout after three failed checks, then the ERROR dwell back to IDLE.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("lock pin entry", current_state, 32'h0004);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("lock req%0d", k), check_req, 32'h1);
      chk($sformatf("lock kind%0d", k), check_kind, 32'h1);
      step(0, 0, 0, 1, 0);
      chk($sformatf("lock clear%0d", k), clear_input, 32'h1);
      if (k < 2) begin
        chk($sformatf("lock stay%0d", k), current_state, 32'h0004);
        step(0, 0, 0, 0, 0);
        chk($sformatf("lock clear_end%0d", k), clear_input, 32'h0);
      end else begin
        chk("lock error", current_state, 32'h2000);
        chk("lock error style", input_style, 32'h0);
      end
      $display("lockout try %0d: state=%04h", k, current_state);
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("lock dwell%0d", j), current_state, 32'h2000);
    end
    step(0, 0, 0, 0, 0);
    chk("lock idle", current_state, 32'h0001);
    chk("lock inactive", session_active, 32'h0);
    $display("lockout: back to state=%04h", current_state);

    // Inactivity timeout in MENU.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("tmo menu", current_state, 32'h0008);
    for (int j = 1; j < 20; j++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("tmo wait%0d", j), current_state, 32'h0008);
    end
    step(0, 0, 0, 0, 0);
    chk("tmo error", current_state, 32'h2000);
    $display("timeout: state=%04h", current_state);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("tmo idle", current_state, 32'h0001);

    // A held ready level gives a single transition.
    step(1, 0, 0, 0, 0);
    chk("hold first", current_state, 32'h0002);
    chk("hold first clear", clear_input, 32'h1);
    for (int j = 1; j < 10; j++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("hold state%0d", j), current_state, 32'h0002);
      chk($sformatf("hold req%0d", j), check_req, 32'h0);
    end
    step(0, 0, 0, 0, 0);
    $display("held ready: state=%04h req=%0b", current_state, check_req);

    // exit_req and check_done on the same edge: exit wins.
    step(1, 0, 0, 0, 0);
    chk("simul req", check_req, 32'h1);
    step(0, 0, 1, 1, 1);
    chk("simul state", current_state, 32'h0001);
    chk("simul req drop", check_req, 32'h0);
    $display("simultaneous exit/done: state=%04h req=%0b", current_state, check_req);

    // Reset while a check is pending.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst pending req", check_req, 32'h1);
    @(negedge clk);
    ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst req", check_req, 32'h0);
    chk("rst state", current_state, 32'h0001);
    $display("reset mid-check: state=%04h req=%0b", current_state, check_req);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
